gtp_rcv_parse: RTL and testbench
================================

Name: gtp_rcv_parse

Overview:
- Main-FPGA receive stage; consumes the 16-bit GTP word stream (data + kchar flag) produced by a channel FPGA's send arbiter.
- Extracts out-of-band trigger K-chars as 1-clk pulses and strips commas.
- Re-frames control-word (CW) delimited blocks and writes them whole into a downstream block FIFO.
- Checks block structure; drops whole blocks the FIFO cannot hold.

Parameters:
FIFO_AW, 11, address width of downstream FIFO; fifo_free is FIFO_AW+1 bits wide
CNT_W, 16, width of saturating error/statistics counters
WDOG_CYCLES, 1023, idle-data timeout in clk cycles (only with RCV_WDOG_EN)

Ports:
clk  in  1  GTP receive user clock
rst_n  in  1  asynchronous active-low reset
link_up  in  1  GTP lane aligned, synchronous to clk
datain  in  16  received word
kchar  in  1  datain is a K-character
fifo_free  in  FIFO_AW+1  free words in downstream FIFO, valid each clk
out_data  out  16  word to FIFO
out_we  out  1  FIFO write strobe
out_last  out  1  with out_we: last word of block
trig  out  1  1-clk trigger pulse
err_undr  out  1  pulse: CW arrived before block complete
err_ovr  out  1  pulse: data word outside any block
err_kchar  out  1  pulse: unknown K-character
err_drop  out  1  pulse: block dropped, no FIFO space
cnt_blocks  out  CNT_W  blocks written, saturating
cnt_errors  out  CNT_W  sum of all error pulses, saturating

Behaviour:
- Reset values: all outputs 0, state HUNT, remaining=0.
- Input classification, evaluated every clk:
  - kchar & datain==16'h801C: trigger.
  - kchar & datain==16'h00BC: comma.
  - Any other kchar word: unknown K-char.
  - ~kchar & datain[15]: CW; N=datain[8:0] data words follow.
  - Otherwise: data word.
- All outputs are registered; latency from datain to out_*/trig/err_* is 1 clk.
- Trigger: trig=1 for one clk; no effect on state or remaining.
- Comma: ignored in every state. Commas and triggers may interleave anywhere inside a block.
- Unknown K-char: err_kchar pulse; otherwise ignored.
- States:
  - HUNT:
    - Data words are discarded silently, with no err_ovr.
    - On CW: same action as IDLE.
  - IDLE (remaining==0):
    - On CW with fifo_free >= N+1: write CW (out_we=1; out_last=1 if N==0), remaining<=N, go to BODY if N>0.
    - On CW with fifo_free < N+1: err_drop pulse, remaining<=N, go to DROP; if N==0, stay IDLE.
    - On data word: err_ovr pulse, word discarded.
  - BODY:
    - On data word: write it, remaining--; when remaining==1, out_last=1 and go to IDLE.
    - On CW: err_undr pulse; the partial block is already in the FIFO and is left there; the new CW is processed exactly as in IDLE in the same clk.
  - DROP:
    - Same counting as BODY; out_we held 0.
    - On CW: err_undr pulse, then processed as in IDLE.
- fifo_free is checked only at the CW; once a block is accepted it is never truncated for space. The FIFO owner guarantees fifo_free does not shrink except by this block's writes.
- link_up low: go to HUNT next clk, remaining<=0, no writes, no error pulses, trig still honoured. Any partial block is abandoned without out_last.
- cnt_blocks increments on each out_last write. cnt_errors adds 1 per clk in which any err_* is asserted. Both counters saturate at all-ones and clear only on reset.
- Asynchronous reset mid-block: immediate return to reset values. The downstream FIFO is reset by the same rst_n.
- Max block length: 512 words (N=511). fifo_free compare uses FIFO_AW+1 bits with no overflow.

Optional Feature:
RCV_WDOG_EN
- Defined:
  - In BODY or DROP, a counter counts consecutive clks without a data word; it resets on every data word or CW.
  - On reaching WDOG_CYCLES: err_undr pulse, remaining<=0, go to IDLE. Nothing is written.
  - The counter is held at 0 in HUNT and IDLE.
- Undefined: no timeout logic; a stalled block waits indefinitely.

Test Plan:
- CW 16'h8003, D1, D2, D3 separated by commas, fifo_free=100 -> 4 writes, out_last with D3, cnt_blocks=1, no errors.
- 16'h801C K-char between CW 16'h8002 and its two data words -> trig pulse 1 clk after input, block written intact.
- CW 16'h8005, 2 data words, then CW 16'h8000 -> err_undr=1 once; 3 words of first block written without out_last; CW 16'h8000 written with out_last=1.
- fifo_free=3, CW 16'h8004 + 4 data -> err_drop=1, no writes; following data word gives err_ovr=1; cnt_errors=2.
- link_up dropped mid-block, restored, then data word -> no err_ovr (HUNT); next CW 16'h8001 + 1 data -> written normally.
- With RCV_WDOG_EN and WDOG_CYCLES=16: CW 16'h8003, one data word, then 16 commas -> err_undr pulse on 16th idle clk; next data word gives err_ovr.

Source files
------------

// File: rtl/gtp_rcv_parse.sv
// gtp_rcv_parse: GTP receive parser - trigger extraction, CW block re-framing into a block FIFO.
// Optional idle-data watchdog inside a block: define RCV_WDOG_EN.
module gtp_rcv_parse #(
   parameter int FIFO_AW     = 11,
   parameter int CNT_W       = 16,
   parameter int WDOG_CYCLES = 1023
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               link_up,
   input  logic [15:0]        datain,
   input  logic               kchar,
   input  logic [FIFO_AW:0]   fifo_free,
   output logic [15:0]        out_data,
   output logic               out_we,
   output logic               out_last,
   output logic               trig,
   output logic               err_undr,
   output logic               err_ovr,
   output logic               err_kchar,
   output logic               err_drop,
   output logic [CNT_W-1:0]   cnt_blocks,
   output logic [CNT_W-1:0]   cnt_errors
);
   typedef enum logic [1:0] {HUNT, IDLE, BODY, DROP} state_t;

   state_t     r_state, w_state;
   logic [8:0] r_rem, w_rem;
   logic [8:0] w_n;
   logic       w_trg, w_com, w_cw, w_dat, w_fit, w_blk, w_tmo;
   logic       w_we, w_last, w_undr, w_ovr, w_kerr, w_drop, w_err;

   assign w_n   = datain[8:0];
   assign w_trg = kchar && datain == 16'h801C;
   assign w_com = kchar && datain == 16'h00BC;
   assign w_cw  = !kchar && datain[15];
   assign w_dat = !kchar && !datain[15];
   assign w_blk = r_state == BODY || r_state == DROP;
   // widened compare so N+1 = 512 never wraps against a narrow fifo_free
   assign w_fit = 32'(fifo_free) >= 32'(w_n) + 32'd1;

`ifdef RCV_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] r_wdog, w_wdog;

   always_comb begin
      w_tmo  = 1'b0;
      w_wdog = '0;
      if (link_up && w_blk && !w_cw && !w_dat) begin
         w_tmo  = r_wdog == WW'(WDOG_CYCLES - 1);
         w_wdog = w_tmo ? '0 : r_wdog + WW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_wdog <= '0;
      else        r_wdog <= w_wdog;
`else
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_state = r_state;
      w_rem   = r_rem;
      w_we    = 1'b0;
      w_last  = 1'b0;
      w_undr  = 1'b0;
      w_ovr   = 1'b0;
      w_drop  = 1'b0;
      w_kerr  = link_up && kchar && !w_trg && !w_com;
      if (!link_up) begin
         w_state = HUNT;
         w_rem   = '0;
      end else if (w_cw) begin
         w_undr  = w_blk;
         w_rem   = w_n;
         w_we    = w_fit;
         w_last  = w_fit && w_n == 9'd0;
         w_drop  = !w_fit;
         w_state = w_n == 9'd0 ? IDLE : (w_fit ? BODY : DROP);
      end else if (w_dat) begin
         if (w_blk) begin
            w_we    = r_state == BODY;
            w_last  = r_state == BODY && r_rem == 9'd1;
            w_rem   = r_rem - 9'd1;
            w_state = r_rem == 9'd1 ? IDLE : r_state;
         end else begin
            w_ovr = r_state == IDLE;
         end
      end else if (w_tmo) begin
         w_undr  = 1'b1;
         w_rem   = '0;
         w_state = IDLE;
      end
   end

   assign w_err = w_undr || w_ovr || w_kerr || w_drop;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state    <= HUNT;
         r_rem      <= '0;
         out_data   <= '0;
         out_we     <= 1'b0;
         out_last   <= 1'b0;
         trig       <= 1'b0;
         err_undr   <= 1'b0;
         err_ovr    <= 1'b0;
         err_kchar  <= 1'b0;
         err_drop   <= 1'b0;
         cnt_blocks <= '0;
         cnt_errors <= '0;
      end else begin
         r_state    <= w_state;
         r_rem      <= w_rem;
         out_data   <= datain;
         out_we     <= w_we;
         out_last   <= w_last;
         trig       <= w_trg;
         err_undr   <= w_undr;
         err_ovr    <= w_ovr;
         err_kchar  <= w_kerr;
         err_drop   <= w_drop;
         cnt_blocks <= cnt_blocks + CNT_W'(w_we && w_last && !(&cnt_blocks));
         cnt_errors <= cnt_errors + CNT_W'(w_err && !(&cnt_errors));
      end
endmodule

// File: tb/tb_gtp_rcv_parse.sv
// tb_gtp_rcv_parse: directed and randomized checks of gtp_rcv_parse against a word-level block model.
module tb_gtp_rcv_parse;
   localparam int AW = 11;
   localparam int WD = 16;

   logic        clk = 0, rst_n = 0, link_up = 0, kchar = 0;
   logic [15:0] datain = 0;
   logic [AW:0] fifo_free = 0;
   logic [15:0] out_data;
   logic        out_we, out_last, trig, err_undr, err_ovr, err_kchar, err_drop;
   logic [15:0] cnt_blocks, cnt_errors;

   gtp_rcv_parse #(.FIFO_AW(AW), .CNT_W(16), .WDOG_CYCLES(WD)) dut (
      .clk(clk), .rst_n(rst_n), .link_up(link_up), .datain(datain), .kchar(kchar),
      .fifo_free(fifo_free), .out_data(out_data), .out_we(out_we), .out_last(out_last),
      .trig(trig), .err_undr(err_undr), .err_ovr(err_ovr), .err_kchar(err_kchar),
      .err_drop(err_drop), .cnt_blocks(cnt_blocks), .cnt_errors(cnt_errors));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // model: words still owed by the open block, whether it is kept, and hunting after link loss
   int          m_left, m_idle, m_blk, m_err;
   bit          m_hunt, m_keep;
   logic [54:0] ev;
   logic [54:0] gv;
   assign gv = {out_we, out_last, out_we ? out_data : 16'h0, trig, err_undr, err_ovr,
                err_kchar, err_drop, cnt_blocks, cnt_errors};

   function automatic logic [17:0] wd(input logic [15:0] x); return {2'b10, x}; endfunction
   function automatic logic [17:0] wk(input logic [15:0] x); return {2'b11, x}; endfunction
   function automatic logic [17:0] wl(); return 18'h0; endfunction

   task automatic model_reset();
      m_left = 0; m_idle = 0; m_blk = 0; m_err = 0; m_hunt = 1; m_keep = 0;
   endtask

   task automatic model(input logic [17:0] s, input logic [AW:0] ff);
      logic        lu = s[17], k = s[16];
      logic [15:0] d = s[15:0];
      logic        we = 0, ls = 0, u = 0, o = 0, ke = 0, dr = 0, tg;
      int          n;
      tg = k && d == 16'h801C;
      if (!lu) begin
         m_left = 0; m_hunt = 1; m_idle = 0;
      end else if (k) begin
         ke = !(d == 16'h801C || d == 16'h00BC);
`ifdef RCV_WDOG_EN
         if (m_left > 0) begin
            m_idle++;
            if (m_idle == WD) begin u = 1; m_left = 0; m_idle = 0; end
         end
`endif
      end else if (d[15]) begin
         n = int'(d[8:0]);
         u = m_left > 0;
         m_hunt = 0;
         m_keep = int'(ff) >= n + 1;
         we = m_keep; ls = m_keep && n == 0; dr = !m_keep;
         m_left = n; m_idle = 0;
      end else begin
         m_idle = 0;
         if (m_left > 0) begin
            we = m_keep; m_left--; ls = m_keep && m_left == 0;
         end else o = !m_hunt;
      end
      if (we && ls && m_blk < 65535) m_blk++;
      if ((u || o || ke || dr) && m_err < 65535) m_err++;
      ev = {we, ls, we ? d : 16'h0, tg, u, o, ke, dr, 16'(m_blk), 16'(m_err)};
   endtask

   task automatic drive(input logic [17:0] s, input logic [AW:0] ff);
      model(s, ff);
      link_up = s[17]; kchar = s[16]; datain = s[15:0]; fifo_free = ff;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      link_up = 1; kchar = 1; datain = 16'h00BC; fifo_free = 0;
      rst_n = 0; #20;
      model_reset();
      @(negedge clk) rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({gv, out_data} !== 71'h0) begin
         errors++; $display("FAIL reset_state got %h want 0", {gv, out_data});
      end
      drive(wd(16'h8005), 100);
      drive(wd(16'h0001), 100);
      #2 rst_n = 0; #1;
      model_reset();
      checks++;
      if ({gv, out_data} !== 71'h0) begin
         errors++; $display("FAIL async_reset got %h want 0", {gv, out_data});
      end
      @(negedge clk) rst_n = 1;
      drive(wd(16'h0002), 100);
      checks++;
      if (gv !== ev || err_ovr !== 1'b0) begin
         errors++; $display("FAIL reset_hunt got %h want %h", gv, ev);
      end
   endtask

   task automatic test_basic();
      logic [17:0] s[$];
      int we = 0, lst = 0, lidx = -1;
      do_reset();
      s = '{wd(16'h8003), wk(16'h00BC), wd(16'h0D01), wk(16'h00BC), wd(16'h0D02),
            wk(16'h00BC), wd(16'h0D03), wk(16'h00BC)};
      foreach (s[i]) begin
         drive(s[i], 100);
         checks++;
         if (gv !== ev) begin errors++; $display("FAIL basic step %0d got %h want %h", i, gv, ev); end
         we += int'(out_we);
         if (out_we && out_last) begin lst++; lidx = i; end
      end
      checks++;
      if (we != 4 || lst != 1 || lidx != 6 || cnt_blocks !== 16'd1 || cnt_errors !== 16'd0) begin
         errors++;
         $display("FAIL basic_totals got we=%0d last=%0d@%0d blk=%0d err=%0d want 4 1@6 1 0",
                  we, lst, lidx, cnt_blocks, cnt_errors);
      end
   endtask

   task automatic test_trig();
      logic [17:0] s[$];
      int we = 0, tn = 0, tidx = -1;
      do_reset();
      s = '{wd(16'h8002), wk(16'h801C), wd(16'h0011), wd(16'h0022)};
      foreach (s[i]) begin
         drive(s[i], 100);
         checks++;
         if (gv !== ev) begin errors++; $display("FAIL trig step %0d got %h want %h", i, gv, ev); end
         we += int'(out_we);
         if (trig) begin tn++; tidx = i; end
      end
      checks++;
      if (we != 3 || tn != 1 || tidx != 1 || cnt_blocks !== 16'd1) begin
         errors++;
         $display("FAIL trig_totals got we=%0d trig=%0d@%0d blk=%0d want 3 1@1 1", we, tn, tidx, cnt_blocks);
      end
   endtask

   task automatic test_undr();
      logic [17:0] s[$];
      int we = 0, lst = 0, un = 0;
      do_reset();
      s = '{wd(16'h8005), wd(16'h0001), wd(16'h0002), wd(16'h8000)};
      foreach (s[i]) begin
         drive(s[i], 100);
         checks++;
         if (gv !== ev) begin errors++; $display("FAIL undr step %0d got %h want %h", i, gv, ev); end
         we += int'(out_we); lst += int'(out_we && out_last); un += int'(err_undr);
      end
      checks++;
      if (we != 4 || lst != 1 || un != 1 || out_last !== 1'b1 || cnt_blocks !== 16'd1) begin
         errors++;
         $display("FAIL undr_totals got we=%0d last=%0d undr=%0d blk=%0d want 4 1 1 1", we, lst, un, cnt_blocks);
      end
   endtask

   task automatic test_drop();
      logic [17:0] s[$];
      int we = 0, dn = 0, on = 0;
      do_reset();
      s = '{wd(16'h8004), wd(16'h0001), wd(16'h0002), wd(16'h0003), wd(16'h0004), wd(16'h0005)};
      foreach (s[i]) begin
         drive(s[i], 3);
         checks++;
         if (gv !== ev) begin errors++; $display("FAIL drop step %0d got %h want %h", i, gv, ev); end
         we += int'(out_we); dn += int'(err_drop); on += int'(err_ovr);
      end
      checks++;
      if (we != 0 || dn != 1 || on != 1 || cnt_errors !== 16'd2) begin
         errors++;
         $display("FAIL drop_totals got we=%0d drop=%0d ovr=%0d err=%0d want 0 1 1 2", we, dn, on, cnt_errors);
      end
   endtask

   task automatic test_link();
      logic [17:0] s[$];
      int we = 0, lst = 0, on = 0;
      do_reset();
      s = '{wd(16'h8003), wd(16'h0001), wl(), wd(16'h0005), wd(16'h8001), wd(16'h0007)};
      foreach (s[i]) begin
         drive(s[i], 100);
         checks++;
         if (gv !== ev) begin errors++; $display("FAIL link step %0d got %h want %h", i, gv, ev); end
         we += int'(out_we); lst += int'(out_we && out_last); on += int'(err_ovr);
      end
      checks++;
      if (we != 4 || lst != 1 || on != 0 || cnt_blocks !== 16'd1 || cnt_errors !== 16'd0) begin
         errors++;
         $display("FAIL link_totals got we=%0d last=%0d ovr=%0d blk=%0d err=%0d want 4 1 0 1 0",
                  we, lst, on, cnt_blocks, cnt_errors);
      end
   endtask

   task automatic test_bound();
      logic [17:0] s[$];
      logic [AW:0] f[$];
      int we = 0, dn = 0, on = 0;
      do_reset();
      s = '{wd(16'h8000), wd(16'h0001), wd(16'h8000), wd(16'h81FF), wl(), wd(16'h81FF), wd(16'h0001), wl()};
      f = '{12'd0, 12'd0, 12'd1, 12'd511, 12'd0, 12'd512, 12'd512, 12'd0};
      foreach (s[i]) begin
         drive(s[i], f[i]);
         checks++;
         if (gv !== ev) begin errors++; $display("FAIL bound step %0d got %h want %h", i, gv, ev); end
         we += int'(out_we); dn += int'(err_drop); on += int'(err_ovr);
      end
      checks++;
      if (we != 3 || dn != 2 || on != 1 || cnt_blocks !== 16'd1) begin
         errors++;
         $display("FAIL bound_totals got we=%0d drop=%0d ovr=%0d blk=%0d want 3 2 1 1", we, dn, on, cnt_blocks);
      end
   endtask

`ifdef RCV_WDOG_EN
   task automatic test_wdog();
      logic [17:0] s[$];
      int uidx = -1, oidx = -1, we = 0;
      do_reset();
      s.push_back(wd(16'h8003));
      s.push_back(wd(16'h0001));
      for (int j = 0; j < WD; j++) s.push_back(wk(16'h00BC));
      s.push_back(wd(16'h0002));
      foreach (s[i]) begin
         drive(s[i], 100);
         checks++;
         if (gv !== ev) begin errors++; $display("FAIL wdog step %0d got %h want %h", i, gv, ev); end
         we += int'(out_we);
         if (err_undr) uidx = i;
         if (err_ovr) oidx = i;
      end
      checks++;
      if (uidx != WD + 1 || oidx != WD + 2 || we != 2) begin
         errors++;
         $display("FAIL wdog_totals got undr@%0d ovr@%0d we=%0d want %0d %0d 2", uidx, oidx, we, WD + 1, WD + 2);
      end
   endtask
`endif

   task automatic test_random();
      logic [17:0] s;
      logic [AW:0] ff;
      int r, bad = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 8)       s = wk(16'h00BC);
         else if (r < 11) s = wk(16'h801C);
         else if (r < 13) s = wk(16'($urandom));
         else if (r < 15) s = wl();
         else if (r < 16) s = wd(16'h8000 | 16'($urandom_range(300, 511)));
         else if (r < 30) s = wd(16'h8000 | 16'($urandom_range(0, 8)));
         else             s = wd(16'($urandom_range(0, 16'h7FFF)));
         ff = ($urandom_range(0, 2) == 0) ? 12'hFFF : 12'($urandom_range(0, 12));
         drive(s, ff);
         checks++;
         if (gv !== ev) begin
            errors++; bad++;
            if (bad < 10) $display("FAIL random step %0d got %h want %h", i, gv, ev);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_trig();
      test_undr();
      test_drop();
      test_link();
      test_bound();
`ifdef RCV_WDOG_EN
      test_wdog();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL sim_timeout");
      $fatal(1);
   end
endmodule
